// File: rtl/min_dist_search.sv
// Nearest-neuron search: scans a bank of RGB centres and reports the minimum
// L1 distance to the current pixel, with the pixel's threshold word alongside.
module min_dist_search #(
    parameter int N_NEURONS = 16,
    parameter int AW        = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pv,
    input  logic [23:0]   px,
    input  logic [15:0]   prx,
    output logic          ready,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [23:0]   wr_data,
    input  logic          wr_valid,
    output logic          rv,
    output logic [15:0]   rx,
    output logic [15:0]   dmin,
    output logic [AW-1:0] dmin_idx,
    output logic          no_match
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(N_NEURONS - 1);

    function automatic logic [7:0] abs_diff8(input logic [7:0] a, input logic [7:0] b);
        abs_diff8 = (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [9:0] l1_rgb(input logic [23:0] a, input logic [23:0] b);
        l1_rgb = {2'd0, abs_diff8(a[23:16], b[23:16])}
               + {2'd0, abs_diff8(a[15:8],  b[15:8])}
               + {2'd0, abs_diff8(a[7:0],   b[7:0])};
    endfunction

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [23:0]     px_q, px_d;
    logic [15:0]     prx_q, prx_d;

    logic            s1_v_q, s1_v_d;
    logic            s1_ok_q, s1_ok_d;
    logic [AW-1:0]   s1_idx_q, s1_idx_d;
    logic [23:0]     s1_c_q, s1_c_d;

    logic            s2_v_q, s2_v_d;
    logic            s2_ok_q, s2_ok_d;
    logic [AW-1:0]   s2_idx_q, s2_idx_d;
    logic [9:0]      s2_dist_q, s2_dist_d;

    logic [15:0]     min_q, min_d;
    logic [AW-1:0]   min_idx_q, min_idx_d;
    logic            found_q, found_d;

    logic            ready_q, ready_d;
    logic            rv_q, rv_d;
    logic [15:0]     rx_q, rx_d;
    logic [15:0]     dmin_q, dmin_d;
    logic [AW-1:0]   dmin_idx_q, dmin_idx_d;
    logic            no_match_q, no_match_d;

    logic [N_NEURONS-1:0] nvalid_q, nvalid_d;
    logic [23:0]          centre_q [N_NEURONS];

    logic            accept_s;
    logic            issue_s;
    logic [AW-1:0]   rd_addr_s;

    assign ready    = ready_q;
    assign rv       = rv_q;
    assign rx       = rx_q;
    assign dmin     = dmin_q;
    assign dmin_idx = dmin_idx_q;
    assign no_match = no_match_q;

    // Next-state, read pipeline, running minimum and result capture
    always_comb begin
        accept_s = ready_q & pv;

        // Slot 0 is read on the accepting edge; later slots follow one per SCAN cycle.
        issue_s   = accept_s | ((state_q == SCAN) && (cnt_q != LAST_IDX));
        rd_addr_s = (state_q == SCAN) ? (cnt_q + AW'(1)) : {AW{1'b0}};

        state_d    = state_q;
        cnt_d      = cnt_q;
        px_d       = px_q;
        prx_d      = prx_q;
        rv_d       = 1'b0;
        rx_d       = rx_q;
        dmin_d     = dmin_q;
        dmin_idx_d = dmin_idx_q;
        no_match_d = no_match_q;

        s1_v_d   = issue_s;
        s1_ok_d  = s1_ok_q;
        s1_idx_d = s1_idx_q;
        s1_c_d   = s1_c_q;
        if (issue_s) begin
            s1_ok_d  = nvalid_q[rd_addr_s];
            s1_idx_d = rd_addr_s;
            s1_c_d   = centre_q[rd_addr_s];
        end else begin
            s1_ok_d  = 1'b0;
        end

        s2_v_d    = s1_v_q;
        s2_ok_d   = s1_ok_q;
        s2_idx_d  = s1_idx_q;
        s2_dist_d = l1_rgb(px_q, s1_c_q);

        min_d     = min_q;
        min_idx_d = min_idx_q;
        found_d   = found_q;
        if (accept_s) begin
            min_d     = 16'hFFFF;
            min_idx_d = {AW{1'b0}};
            found_d   = 1'b0;
        end else if (s2_v_q && s2_ok_q && ({6'd0, s2_dist_q} < min_q)) begin
            min_d     = {6'd0, s2_dist_q};
            min_idx_d = s2_idx_q;
            found_d   = 1'b1;
        end else begin
            min_d     = min_q;
        end

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = SCAN;
                    cnt_d   = {AW{1'b0}};
                    px_d    = px;
                    prx_d   = prx;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = FLUSH;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            FLUSH: begin
                // The last slot's compare lands on this edge, so capture min_d.
                state_d    = DONE;
                rv_d       = 1'b1;
                rx_d       = prx_q;
                dmin_d     = min_d;
                dmin_idx_d = min_idx_d;
                no_match_d = ~found_d;
            end
            DONE: begin
                if (accept_s) begin
                    state_d = SCAN;
                    cnt_d   = {AW{1'b0}};
                    px_d    = px;
                    prx_d   = prx;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE) || (state_d == DONE);

        nvalid_d = nvalid_q;
        if (wr_en) begin
            nvalid_d[wr_addr] = wr_valid;
        end else begin
            nvalid_d = nvalid_q;
        end
    end

    // Control, pipeline and output registers; reset also empties the bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= {AW{1'b0}};
            px_q       <= 24'd0;
            prx_q      <= 16'd0;
            s1_v_q     <= 1'b0;
            s1_ok_q    <= 1'b0;
            s1_idx_q   <= {AW{1'b0}};
            s1_c_q     <= 24'd0;
            s2_v_q     <= 1'b0;
            s2_ok_q    <= 1'b0;
            s2_idx_q   <= {AW{1'b0}};
            s2_dist_q  <= 10'd0;
            min_q      <= 16'hFFFF;
            min_idx_q  <= {AW{1'b0}};
            found_q    <= 1'b0;
            ready_q    <= 1'b1;
            rv_q       <= 1'b0;
            rx_q       <= 16'd0;
            dmin_q     <= 16'd0;
            dmin_idx_q <= {AW{1'b0}};
            no_match_q <= 1'b0;
            nvalid_q   <= {N_NEURONS{1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            px_q       <= px_d;
            prx_q      <= prx_d;
            s1_v_q     <= s1_v_d;
            s1_ok_q    <= s1_ok_d;
            s1_idx_q   <= s1_idx_d;
            s1_c_q     <= s1_c_d;
            s2_v_q     <= s2_v_d;
            s2_ok_q    <= s2_ok_d;
            s2_idx_q   <= s2_idx_d;
            s2_dist_q  <= s2_dist_d;
            min_q      <= min_d;
            min_idx_q  <= min_idx_d;
            found_q    <= found_d;
            ready_q    <= ready_d;
            rv_q       <= rv_d;
            rx_q       <= rx_d;
            dmin_q     <= dmin_d;
            dmin_idx_q <= dmin_idx_d;
            no_match_q <= no_match_d;
            nvalid_q   <= nvalid_d;
        end
    end

    // Centre storage; contents are meaningless until the valid bit is set
    always_ff @(posedge clk) begin
        if (wr_en) begin
            centre_q[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_min_dist_search.sv
// Directed bench for min_dist_search: table of pixel vectors plus hand-written
// sequences for ties, writes during a scan, back-to-back pixels and reset mid-scan.
module tb_min_dist_search;

    localparam int LAT = 18;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pv = 1'b0;
    logic [23:0] px = 24'd0;
    logic [15:0] prx = 16'd0;
    logic        ready;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = 4'd0;
    logic [23:0] wr_data = 24'd0;
    logic        wr_valid = 1'b0;
    logic        rv;
    logic [15:0] rx;
    logic [15:0] dmin;
    logic [3:0]  dmin_idx;
    logic        no_match;

    int n_cmp = 0;
    int n_err = 0;

    min_dist_search #(.N_NEURONS(16), .AW(4)) dut (
        .clk(clk), .rst(rst), .pv(pv), .px(px), .prx(prx), .ready(ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid),
        .rv(rv), .rx(rx), .dmin(dmin), .dmin_idx(dmin_idx), .no_match(no_match)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] px;
        logic [15:0] prx;
        logic [15:0] dmin;
        logic [3:0]  idx;
        logic        nm;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_slot(input logic [3:0] a, input logic [23:0] d, input logic v);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_valid = v;
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Presents one pixel while ready, then counts cycles after the accepting edge until rv.
    task automatic run_pixel(input logic [23:0] p, input logic [15:0] r, output int lat);
        px = p; prx = r; pv = 1'b1;
        step();
        pv = 1'b0;
        lat = 1;
        while (!rv && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic check_px(input string name, input logic [23:0] p, input logic [15:0] r,
                            input logic [15:0] e_dmin, input logic [3:0] e_idx, input logic e_nm);
        int lat;
        run_pixel(p, r, lat);
        chk({name, ".latency"}, lat, LAT);
        chk({name, ".rx"}, rx, r);
        chk({name, ".dmin"}, dmin, e_dmin);
        chk({name, ".dmin_idx"}, dmin_idx, e_idx);
        chk({name, ".no_match"}, no_match, e_nm);
        chk({name, ".ready_with_rv"}, ready, 1'b1);
        step();
        chk({name, ".rv_one_cycle"}, rv, 1'b0);
        chk({name, ".dmin_held"}, dmin, e_dmin);
    endtask

    logic [23:0] b2b_px  [3];
    logic [15:0] b2b_rx  [3];
    logic [15:0] b2b_d   [3];

    initial begin
        int lat;
        int cyc;
        int r;
        int last_rv;
        int bad_ready;
        int rv_seen;

        // bank for the table: slot3=102030, slot7=800000, slot12=0F1F2F but invalid
        tbl[0] = '{24'h102030, 16'h0001, 16'd0,   4'd3, 1'b0};
        tbl[1] = '{24'h7F0000, 16'h0002, 16'd1,   4'd7, 1'b0};
        tbl[2] = '{24'hFFFFFF, 16'h0003, 16'd637, 4'd7, 1'b0};
        tbl[3] = '{24'h000000, 16'h0004, 16'd96,  4'd3, 1'b0};
        tbl[4] = '{24'h484040, 16'h0005, 16'd104, 4'd3, 1'b0};
        tbl[5] = '{24'h0F1F2F, 16'h0006, 16'd3,   4'd3, 1'b0};

        b2b_px[0] = 24'h808081; b2b_rx[0] = 16'h0101; b2b_d[0] = 16'd0;
        b2b_px[1] = 24'h000000; b2b_rx[1] = 16'h0202; b2b_d[1] = 16'd385;
        b2b_px[2] = 24'h818283; b2b_rx[2] = 16'h0303; b2b_d[2] = 16'd5;

        step();
        step();
        rst = 1'b0;
        step();
        chk("reset.ready", ready, 1'b1);
        chk("reset.rv", rv, 1'b0);
        chk("reset.rx", rx, 16'd0);
        chk("reset.dmin", dmin, 16'd0);
        chk("reset.dmin_idx", dmin_idx, 4'd0);
        chk("reset.no_match", no_match, 1'b0);

        check_px("empty", 24'h123456, 16'hAAAA, 16'hFFFF, 4'd0, 1'b1);

        write_slot(4'd3, 24'h102030, 1'b1);
        check_px("single", 24'h0F1F2F, 16'h1234, 16'd3, 4'd3, 1'b0);

        write_slot(4'd7, 24'h800000, 1'b1);
        write_slot(4'd12, 24'h0F1F2F, 1'b0);
        for (int i = 0; i < 6; i++) begin
            check_px($sformatf("tbl%0d", i), tbl[i].px, tbl[i].prx, tbl[i].dmin, tbl[i].idx, tbl[i].nm);
        end

        do_reset();
        write_slot(4'd9, 24'h000000, 1'b1);
        write_slot(4'd2, 24'h000000, 1'b1);
        check_px("tie", 24'hFFFFFF, 16'h7777, 16'h02FD, 4'd2, 1'b0);

        // write slot 10 and invalidate slot 0 after slot 0 has been read
        do_reset();
        write_slot(4'd0, 24'h808080, 1'b1);
        px = 24'h808080; prx = 16'h5A5A; pv = 1'b1;
        step();
        pv = 1'b0;
        lat = 1;
        while (!rv && lat < 40) begin
            if (lat == 5) begin
                wr_en = 1'b1; wr_addr = 4'd10; wr_data = 24'h808081; wr_valid = 1'b1;
            end else if (lat == 6) begin
                wr_en = 1'b1; wr_addr = 4'd0; wr_data = 24'h808080; wr_valid = 1'b0;
            end else begin
                wr_en = 1'b0;
            end
            step();
            lat++;
        end
        wr_en = 1'b0;
        chk("wscan.latency", lat, LAT);
        chk("wscan.dmin", dmin, 16'd0);
        chk("wscan.dmin_idx", dmin_idx, 4'd0);
        chk("wscan.no_match", no_match, 1'b0);
        step();
        check_px("wscan_after", 24'h808080, 16'h5A5B, 16'd1, 4'd10, 1'b0);

        // back-to-back with pv held high
        px = b2b_px[0]; prx = b2b_rx[0]; pv = 1'b1;
        cyc = 0; r = 0; last_rv = 0; bad_ready = 0;
        while (r < 3 && cyc < 100) begin
            step();
            cyc++;
            if (rv) begin
                chk($sformatf("b2b%0d.spacing", r), cyc - last_rv, LAT);
                chk($sformatf("b2b%0d.rx", r), rx, b2b_rx[r]);
                chk($sformatf("b2b%0d.dmin", r), dmin, b2b_d[r]);
                chk($sformatf("b2b%0d.dmin_idx", r), dmin_idx, 4'd10);
                last_rv = cyc;
                r++;
                if (r < 3) begin
                    px = b2b_px[r]; prx = b2b_rx[r];
                end else begin
                    pv = 1'b0;
                end
            end else if (ready) begin
                bad_ready++;
            end
        end
        pv = 1'b0;
        chk("b2b.results", r, 3);
        chk("b2b.ready_in_scan", bad_ready, 0);
        step();

        // reset part-way through a scan
        px = 24'h808081; prx = 16'hBEEF; pv = 1'b1;
        step();
        pv = 1'b0;
        rv_seen = 0;
        for (int i = 1; i < 7; i++) begin
            step();
            if (rv) rv_seen++;
        end
        rst = 1'b1;
        #1;
        chk("rstmid.ready", ready, 1'b1);
        chk("rstmid.rv", rv, 1'b0);
        chk("rstmid.rx", rx, 16'd0);
        chk("rstmid.dmin", dmin, 16'd0);
        chk("rstmid.dmin_idx", dmin_idx, 4'd0);
        chk("rstmid.no_match", no_match, 1'b0);
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (rv) rv_seen++;
        end
        chk("rstmid.no_rv", rv_seen, 0);
        check_px("rstmid_next", 24'h808081, 16'hC0DE, 16'hFFFF, 4'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
